// File: rtl/echo_app_tx_msg_if_ctrl.sv
// Echo TX message interface: per queued descriptor, reserve TX space, copy RX payload, adjust TX tail. Optional ECHO_TX_PERF_CNT_EN adds retire counters.
// Push->tx_req_val 2 cycles minimum; one descriptor in flight, msg_in_rdy drops when the descriptor FIFO is full.
module echo_app_tx_msg_if_ctrl #(
  parameter int FLOWID_W      = 8,
  parameter int LEN_W         = 16,
  parameter int RX_PTR_W      = 16,
  parameter int TX_PTR_W      = 16,
  parameter int APP_HDR_BYTES = 8,
  parameter int Q_DEPTH       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                msg_in_val,
  input  logic [FLOWID_W-1:0] msg_in_flowid,
  input  logic [LEN_W-1:0]    msg_in_len,
  input  logic [RX_PTR_W:0]   msg_in_head_ptr,
  output logic                msg_in_rdy,
  output logic                tx_req_val,
  output logic                tx_req_adjust,
  output logic [FLOWID_W-1:0] tx_req_flowid,
  output logic [LEN_W-1:0]    tx_req_len,
  output logic [TX_PTR_W:0]   tx_req_ptr,
  input  logic                tx_req_rdy,
  input  logic                tx_resp_val,
  input  logic [TX_PTR_W:0]   tx_resp_tail_ptr,
  output logic                tx_resp_rdy,
  output logic                copy_cmd_val,
  output logic [FLOWID_W-1:0] copy_cmd_flowid,
  output logic [RX_PTR_W:0]   copy_cmd_src_ptr,
  output logic [TX_PTR_W:0]   copy_cmd_dst_ptr,
  output logic [LEN_W-1:0]    copy_cmd_len,
  input  logic                copy_cmd_rdy,
  input  logic                copy_done,
  output logic                done_val,
  output logic [FLOWID_W-1:0] done_flowid
`ifdef ECHO_TX_PERF_CNT_EN
  ,
  output logic [31:0]         perf_msg_cnt,
  output logic [47:0]         perf_byte_cnt
`endif
);

  localparam int RXP = RX_PTR_W + 1;
  localparam int TXP = TX_PTR_W + 1;
  localparam int QAW = $clog2(Q_DEPTH);

  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    logic [LEN_W-1:0]    len;
    logic [RXP-1:0]      head_ptr;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_SPACE,
    S_WAIT_SPACE,
    S_COPY,
    S_WAIT_COPY,
    S_PTR_UPD
  } state_t;

  desc_t               fifo_mem_q [Q_DEPTH];
  logic [QAW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                fifo_empty, fifo_full, push;
  desc_t               head;

  state_t              state_q, state_d;
  logic [FLOWID_W-1:0] flowid_q, flowid_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [RXP-1:0]      src_ptr_q, src_ptr_d;
  logic [TXP-1:0]      tail_q, tail_d;
  logic                tx_req_val_q, tx_req_val_d;
  logic                tx_req_adjust_q, tx_req_adjust_d;
  logic [LEN_W-1:0]    tx_req_len_q, tx_req_len_d;
  logic [TXP-1:0]      tx_req_ptr_q, tx_req_ptr_d;
  logic                tx_resp_rdy_q, tx_resp_rdy_d;
  logic                copy_cmd_val_q, copy_cmd_val_d;
  logic                zl_done_q, zl_done_d;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[QAW] != rd_ptr_q[QAW]) &&
                      (wr_ptr_q[QAW-1:0] == rd_ptr_q[QAW-1:0]);
  assign push       = msg_in_val & ~fifo_full;
  assign head       = fifo_mem_q[rd_ptr_q[QAW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[QAW-1:0]] <= {msg_in_flowid, msg_in_len, msg_in_head_ptr};
    end
  end

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    flowid_d        = flowid_q;
    len_d           = len_q;
    src_ptr_d       = src_ptr_q;
    tail_d          = tail_q;
    tx_req_val_d    = tx_req_val_q;
    tx_req_adjust_d = tx_req_adjust_q;
    tx_req_len_d    = tx_req_len_q;
    tx_req_ptr_d    = tx_req_ptr_q;
    tx_resp_rdy_d   = tx_resp_rdy_q;
    copy_cmd_val_d  = copy_cmd_val_q;
    zl_done_d       = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + (QAW+1)'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          rd_ptr_d  = rd_ptr_q + (QAW+1)'(1);
          flowid_d  = head.flowid;
          len_d     = head.len;
          src_ptr_d = head.head_ptr + RXP'(APP_HDR_BYTES);
          // Zero-length messages retire without touching the TX tile or data mover.
          if (head.len != '0) begin
            state_d         = S_REQ_SPACE;
            tx_req_val_d    = 1'b1;
            tx_req_adjust_d = 1'b0;
            tx_req_len_d    = head.len;
            tx_req_ptr_d    = '0;
          end else begin
            zl_done_d = 1'b1;
          end
        end
      end
      S_REQ_SPACE: begin
        if (tx_req_rdy) begin
          state_d       = S_WAIT_SPACE;
          tx_req_val_d  = 1'b0;
          tx_resp_rdy_d = 1'b1;
        end
      end
      S_WAIT_SPACE: begin
        if (tx_resp_val) begin
          state_d        = S_COPY;
          tail_d         = tx_resp_tail_ptr;
          tx_resp_rdy_d  = 1'b0;
          copy_cmd_val_d = 1'b1;
        end
      end
      S_COPY: begin
        if (copy_cmd_rdy) begin
          state_d        = S_WAIT_COPY;
          copy_cmd_val_d = 1'b0;
        end
      end
      S_WAIT_COPY: begin
        if (copy_done) begin
          state_d         = S_PTR_UPD;
          tx_req_val_d    = 1'b1;
          tx_req_adjust_d = 1'b1;
          tx_req_len_d    = '0;
          tx_req_ptr_d    = tail_q + TXP'(len_q);
        end
      end
      S_PTR_UPD: begin
        if (tx_req_rdy) begin
          state_d         = S_IDLE;
          tx_req_val_d    = 1'b0;
          tx_req_adjust_d = 1'b0;
          tx_req_ptr_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      flowid_q        <= '0;
      len_q           <= '0;
      src_ptr_q       <= '0;
      tail_q          <= '0;
      tx_req_val_q    <= 1'b0;
      tx_req_adjust_q <= 1'b0;
      tx_req_len_q    <= '0;
      tx_req_ptr_q    <= '0;
      tx_resp_rdy_q   <= 1'b0;
      copy_cmd_val_q  <= 1'b0;
      zl_done_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      flowid_q        <= flowid_d;
      len_q           <= len_d;
      src_ptr_q       <= src_ptr_d;
      tail_q          <= tail_d;
      tx_req_val_q    <= tx_req_val_d;
      tx_req_adjust_q <= tx_req_adjust_d;
      tx_req_len_q    <= tx_req_len_d;
      tx_req_ptr_q    <= tx_req_ptr_d;
      tx_resp_rdy_q   <= tx_resp_rdy_d;
      copy_cmd_val_q  <= copy_cmd_val_d;
      zl_done_q       <= zl_done_d;
    end
  end

  assign msg_in_rdy       = ~fifo_full;
  assign tx_req_val       = tx_req_val_q;
  assign tx_req_adjust    = tx_req_adjust_q;
  assign tx_req_flowid    = flowid_q;
  assign tx_req_len       = tx_req_len_q;
  assign tx_req_ptr       = tx_req_ptr_q;
  assign tx_resp_rdy      = tx_resp_rdy_q;
  assign copy_cmd_val     = copy_cmd_val_q;
  assign copy_cmd_flowid  = flowid_q;
  assign copy_cmd_src_ptr = src_ptr_q;
  assign copy_cmd_dst_ptr = tail_q;
  assign copy_cmd_len     = len_q;
  // Pointer-adjust retirement is reported in the cycle the TX tile accepts it.
  assign done_val         = ~rst & (zl_done_q | ((state_q == S_PTR_UPD) & tx_req_rdy));
  assign done_flowid      = flowid_q;

`ifdef ECHO_TX_PERF_CNT_EN
  logic [31:0] perf_msg_cnt_q, perf_msg_cnt_d;
  logic [47:0] perf_byte_cnt_q, perf_byte_cnt_d;

  always_comb begin
    perf_msg_cnt_d  = perf_msg_cnt_q;
    perf_byte_cnt_d = perf_byte_cnt_q;
    if (done_val) begin
      perf_msg_cnt_d  = perf_msg_cnt_q + 32'd1;
      perf_byte_cnt_d = perf_byte_cnt_q + 48'(len_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_msg_cnt_q  <= '0;
      perf_byte_cnt_q <= '0;
    end else begin
      perf_msg_cnt_q  <= perf_msg_cnt_d;
      perf_byte_cnt_q <= perf_byte_cnt_d;
    end
  end

  assign perf_msg_cnt  = perf_msg_cnt_q;
  assign perf_byte_cnt = perf_byte_cnt_q;
`endif

endmodule

// File: tb/tb_echo_app_tx_msg_if_ctrl.sv
// Scoreboard bench for echo_app_tx_msg_if_ctrl: directed descriptors, TX-tile and data-mover responders, monitor compares handshakes.
module tb_echo_app_tx_msg_if_ctrl;

  logic        clk;
  logic        rst;
  logic        msg_in_val;
  logic [7:0]  msg_in_flowid;
  logic [15:0] msg_in_len;
  logic [16:0] msg_in_head_ptr;
  logic        msg_in_rdy;
  logic        tx_req_val;
  logic        tx_req_adjust;
  logic [7:0]  tx_req_flowid;
  logic [15:0] tx_req_len;
  logic [16:0] tx_req_ptr;
  logic        tx_req_rdy;
  logic        tx_resp_val;
  logic [16:0] tx_resp_tail_ptr;
  logic        tx_resp_rdy;
  logic        copy_cmd_val;
  logic [7:0]  copy_cmd_flowid;
  logic [16:0] copy_cmd_src_ptr;
  logic [16:0] copy_cmd_dst_ptr;
  logic [15:0] copy_cmd_len;
  logic        copy_cmd_rdy;
  logic        copy_done;
  logic        done_val;
  logic [7:0]  done_flowid;
`ifdef ECHO_TX_PERF_CNT_EN
  logic [31:0] perf_msg_cnt;
  logic [47:0] perf_byte_cnt;
`endif

  echo_app_tx_msg_if_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .msg_in_val       (msg_in_val),
    .msg_in_flowid    (msg_in_flowid),
    .msg_in_len       (msg_in_len),
    .msg_in_head_ptr  (msg_in_head_ptr),
    .msg_in_rdy       (msg_in_rdy),
    .tx_req_val       (tx_req_val),
    .tx_req_adjust    (tx_req_adjust),
    .tx_req_flowid    (tx_req_flowid),
    .tx_req_len       (tx_req_len),
    .tx_req_ptr       (tx_req_ptr),
    .tx_req_rdy       (tx_req_rdy),
    .tx_resp_val      (tx_resp_val),
    .tx_resp_tail_ptr (tx_resp_tail_ptr),
    .tx_resp_rdy      (tx_resp_rdy),
    .copy_cmd_val     (copy_cmd_val),
    .copy_cmd_flowid  (copy_cmd_flowid),
    .copy_cmd_src_ptr (copy_cmd_src_ptr),
    .copy_cmd_dst_ptr (copy_cmd_dst_ptr),
    .copy_cmd_len     (copy_cmd_len),
    .copy_cmd_rdy     (copy_cmd_rdy),
    .copy_done        (copy_done),
    .done_val         (done_val),
    .done_flowid      (done_flowid)
`ifdef ECHO_TX_PERF_CNT_EN
    ,
    .perf_msg_cnt     (perf_msg_cnt),
    .perf_byte_cnt    (perf_byte_cnt)
`endif
  );

  typedef struct packed {
    logic        adjust;
    logic [7:0]  flowid;
    logic [15:0] len;
    logic [16:0] ptr;
  } req_t;

  typedef struct packed {
    logic [7:0]  flowid;
    logic [16:0] src;
    logic [16:0] dst;
    logic [15:0] len;
  } cp_t;

  req_t        exp_req[$];
  cp_t         exp_copy[$];
  logic [7:0]  exp_done[$];
  logic [16:0] grant_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          dm_auto  = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: DUT output with no expected entry", name);
  endtask

  // TX tile grants space one cycle after a space request; data mover completes one cycle after accepting.
  initial begin : env
    bit s_req, s_resp, s_copy, resp_pending;
    resp_pending = 1'b0;
    forever begin
      @(negedge clk);
      s_req  = tx_req_val & tx_req_rdy & ~tx_req_adjust;
      s_resp = tx_resp_val & tx_resp_rdy;
      s_copy = copy_cmd_val & copy_cmd_rdy;
      @(posedge clk);
      #1;
      if (s_resp) tx_resp_val = 1'b0;
      if (s_req) resp_pending = 1'b1;
      if (resp_pending && !tx_resp_val) begin
        if (grant_q.size() > 0) tx_resp_tail_ptr = grant_q.pop_front();
        tx_resp_val  = 1'b1;
        resp_pending = 1'b0;
      end
      if (dm_auto) copy_done = s_copy;
    end
  end

  initial begin : monitor
    req_t       r;
    cp_t        c;
    logic [7:0] f;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_req_val && tx_req_rdy) begin
          if (exp_req.size() == 0) unexpected("tx_req");
          else begin
            r = exp_req.pop_front();
            chk("tx_req_adjust", tx_req_adjust, r.adjust);
            chk("tx_req_flowid", tx_req_flowid, r.flowid);
            chk("tx_req_len", tx_req_len, r.len);
            chk("tx_req_ptr", tx_req_ptr, r.ptr);
          end
        end
        if (copy_cmd_val && copy_cmd_rdy) begin
          if (exp_copy.size() == 0) unexpected("copy_cmd");
          else begin
            c = exp_copy.pop_front();
            chk("copy_flowid", copy_cmd_flowid, c.flowid);
            chk("copy_src", copy_cmd_src_ptr, c.src);
            chk("copy_dst", copy_cmd_dst_ptr, c.dst);
            chk("copy_len", copy_cmd_len, c.len);
          end
        end
        if (done_val) begin
          if (exp_done.size() == 0) unexpected("done");
          else begin
            f = exp_done.pop_front();
            chk("done_flowid", done_flowid, f);
          end
        end
      end
    end
  end

  // Expected src/new-tail are hand-computed by the caller; full=0 omits the adjust and done.
  task automatic send(input logic [7:0] fl, input logic [15:0] ln, input logic [16:0] hd,
                      input logic [16:0] tl, input logic [16:0] e_src, input logic [16:0] e_tail,
                      input bit full);
    int w;
    if (ln != 16'd0) begin
      exp_req.push_back('{1'b0, fl, ln, 17'd0});
      exp_copy.push_back('{fl, e_src, tl, ln});
      grant_q.push_back(tl);
      if (full) exp_req.push_back('{1'b1, fl, 16'd0, e_tail});
    end
    if (full) exp_done.push_back(fl);
    msg_in_val      = 1'b1;
    msg_in_flowid   = fl;
    msg_in_len      = ln;
    msg_in_head_ptr = hd;
    w = 0;
    @(negedge clk);
    while (!msg_in_rdy && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!msg_in_rdy) unexpected("push_timeout");
    @(posedge clk);
    #1;
    msg_in_val = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int w;
    w = 0;
    while ((exp_req.size() + exp_copy.size() + exp_done.size()) != 0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk(name, exp_req.size() + exp_copy.size() + exp_done.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  bp_fl   [5] = '{8'd20, 8'd21, 8'd22, 8'd23, 8'd24};
  logic [15:0] bp_len  [5] = '{16'd4, 16'd8, 16'd12, 16'd16, 16'd20};
  logic [16:0] bp_hd   [5] = '{17'h00000, 17'h00040, 17'h00080, 17'h000C0, 17'h00100};
  logic [16:0] bp_src  [5] = '{17'h00008, 17'h00048, 17'h00088, 17'h000C8, 17'h00108};
  logic [16:0] bp_tl   [5] = '{17'h01000, 17'h01100, 17'h01200, 17'h01300, 17'h01400};
  logic [16:0] bp_ntl  [5] = '{17'h01004, 17'h01108, 17'h0120C, 17'h01310, 17'h01414};

  initial begin : stim
    int k, cnt;
    rst              = 1'b1;
    msg_in_val       = 1'b0;
    msg_in_flowid    = '0;
    msg_in_len       = '0;
    msg_in_head_ptr  = '0;
    tx_req_rdy       = 1'b1;
    tx_resp_val      = 1'b0;
    tx_resp_tail_ptr = '0;
    copy_cmd_rdy     = 1'b1;
    copy_done        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_msg_in_rdy", msg_in_rdy, 1);
    chk("rst_tx_req_val", tx_req_val, 0);
    chk("rst_tx_resp_rdy", tx_resp_rdy, 0);
    chk("rst_copy_cmd_val", copy_cmd_val, 0);
    chk("rst_done_val", done_val, 0);
    chk("rst_tx_req_ptr", tx_req_ptr, 0);
    chk("rst_copy_dst", copy_cmd_dst_ptr, 0);
    chk("rst_done_flowid", done_flowid, 0);
    @(posedge clk);
    #1;

    // Basic echo, plus push->tx_req_val latency.
    send(8'd3, 16'd64, 17'h00010, 17'h00100, 17'h00018, 17'h00140, 1'b1);
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (tx_req_val) break;
    end
    chk("basic_req_latency", k, 2);
    drain("basic_drain", 200);

    // Zero-length retires two cycles after push with no TX/copy traffic.
    send(8'd5, 16'd0, 17'h00030, 17'h0, 17'h0, 17'h0, 1'b1);
    cnt = 0;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      cnt += int'(tx_req_val) + int'(copy_cmd_val);
      if (done_val) break;
    end
    chk("zl_done_latency", k, 2);
    chk("zl_no_traffic", cnt, 0);
    drain("zl_drain", 50);

    // TX tail wraps past 2^16; RX source wraps past 2^17.
    send(8'd9, 16'd32, 17'h1FFFC, 17'h0FFF0, 17'h00004, 17'h10010, 1'b1);
    drain("wrap_drain", 200);

    // Stall the TX tile, fill the FIFO behind the in-flight descriptor.
    tx_req_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(bp_fl[i], bp_len[i], bp_hd[i], bp_tl[i], bp_src[i], bp_ntl[i], 1'b1);
      if (i >= 3) begin
        @(negedge clk);
        chk(i == 3 ? "bp_rdy_after4" : "bp_rdy_full", msg_in_rdy, i == 3 ? 1 : 0);
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    chk("bp_req_held", tx_req_val, 1);
    chk("bp_req_held_flow", tx_req_flowid, 20);
    @(posedge clk);
    #1;
    tx_req_rdy = 1'b1;
    drain("bp_drain", 2000);

    // Reset while waiting for copy completion; a late copy_done must be ignored.
    dm_auto = 1'b0;
    send(8'd7, 16'd16, 17'h00020, 17'h00200, 17'h00028, 17'h00210, 1'b0);
    k = 0;
    while (exp_copy.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rstmid_copy_seen", exp_copy.size(), 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_tx_req_val", tx_req_val, 0);
    chk("rstmid_copy_val", copy_cmd_val, 0);
    chk("rstmid_resp_rdy", tx_resp_rdy, 0);
    chk("rstmid_done_val", done_val, 0);
    chk("rstmid_msg_in_rdy", msg_in_rdy, 1);
    @(posedge clk);
    #1;
    copy_done = 1'b1;
    @(posedge clk);
    #1;
    copy_done = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(done_val) + int'(tx_req_val);
    end
    chk("rstmid_stray_copy_done", cnt, 0);
    @(posedge clk);
    #1;
    dm_auto = 1'b1;
    send(8'd8, 16'd4, 17'h00050, 17'h00300, 17'h00058, 17'h00304, 1'b1);
    drain("post_rst_drain", 200);

`ifdef ECHO_TX_PERF_CNT_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'd30, 16'd10, 17'h00000, 17'h00400, 17'h00008, 17'h0040A, 1'b1);
    send(8'd31, 16'd0, 17'h00000, 17'h0, 17'h0, 17'h0, 1'b1);
    send(8'd32, 16'd30, 17'h00100, 17'h00500, 17'h00108, 17'h0051E, 1'b1);
    drain("perf_drain", 500);
    @(negedge clk);
    chk("perf_msg_cnt", perf_msg_cnt, 3);
    chk("perf_byte_cnt", perf_byte_cnt, 40);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
